// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes, FSM
// states, instruction classes and the select codes seen by the datapath.
package multicycle_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HLT  = 3'd6
    } state_t;

    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_JAL  = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;
    localparam logic [1:0] PCSRC_BR   = 2'b11;

    localparam logic [1:0] WBSRC_ALU  = 2'b00;
    localparam logic [1:0] WBSRC_LOAD = 2'b01;
    localparam logic [1:0] WBSRC_PC4  = 2'b10;

    localparam logic [1:0] OPSRC_RFWD = 2'b00;
    localparam logic [1:0] OPSRC_ALU  = 2'b01;
    localparam logic [1:0] OPSRC_BR   = 2'b10;

    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic unknown;
    } inst_class_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// One-hot instruction class from the 7-bit opcode; anything unrecognised
// is flagged so the controller can retire it as a NOP.
module inst_class_decode
    import multicycle_pkg::*;
(
    input  logic [6:0]  opcode,
    output inst_class_t cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: cls.alu = 1'b1;
            OPC_LOAD:   cls.load   = 1'b1;
            OPC_STORE:  cls.store  = 1'b1;
            OPC_BRANCH: cls.branch = 1'b1;
            OPC_JAL:    cls.jal    = 1'b1;
            OPC_JALR:   cls.jalr   = 1'b1;
            default:    cls.unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB,
// counts retired instructions and stops on the addi/jalr halt pair.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter logic [31:0] HALT_PREV = 32'h00c00093,
    parameter logic [31:0] HALT_CUR  = 32'h00008067
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IR,
    input  logic        I_MEM_RDY,
    input  logic        D_MEM_RDY,
    input  logic        Branch_Cond,
    output logic        I_MEM_REQ,
    output logic        IR_WE,
    output logic        PC_WE,
    output logic [1:0]  PCSrc,
    output logic        RF_WE,
    output logic [1:0]  WBSrc,
    output logic        D_MEM_REQ,
    output logic        D_MEM_WE,
    output logic [1:0]  OPSrc,
    output logic        INST_DONE,
    output logic [31:0] NUM_INST,
    output logic        HALT
);

    state_t      state, state_next;
    inst_class_t cls;
    logic [31:0] last_inst;
    logic        is_halt;
    logic        unused_branch_cond;

    // The datapath resolves taken/not-taken itself from PCSrc=BR.
    assign unused_branch_cond = Branch_Cond;

    inst_class_decode u_decode (
        .opcode (IR[6:0]),
        .cls    (cls)
    );

    assign is_halt = (last_inst == HALT_PREV) && (IR == HALT_CUR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_INIT: state_next = S_IF;
            S_IF:   if (I_MEM_RDY) state_next = S_ID;
            S_ID: begin
                if (is_halt)          state_next = S_HLT;
                else if (cls.unknown) state_next = S_IF;
                else                  state_next = S_EX;
            end
            S_EX: begin
                if (cls.branch)                 state_next = S_IF;
                else if (cls.load || cls.store) state_next = S_MEM;
                else                            state_next = S_WB;
            end
            S_MEM: if (D_MEM_RDY) state_next = cls.store ? S_IF : S_WB;
            S_WB:  state_next = S_IF;
            S_HLT: state_next = S_HLT;
            default: state_next = S_INIT;
        endcase
    end

    always_comb begin
        I_MEM_REQ = 1'b0;
        IR_WE     = 1'b0;
        PC_WE     = 1'b0;
        PCSrc     = PCSRC_PC4;
        RF_WE     = 1'b0;
        WBSrc     = WBSRC_ALU;
        D_MEM_REQ = 1'b0;
        D_MEM_WE  = 1'b0;
        OPSrc     = OPSRC_RFWD;
        INST_DONE = 1'b0;
        HALT      = 1'b0;
        case (state)
            S_IF: begin
                I_MEM_REQ = 1'b1;
                IR_WE     = I_MEM_RDY;
            end
            S_ID: begin
                if (!is_halt && cls.unknown) begin
                    PC_WE     = 1'b1;
                    INST_DONE = 1'b1;
                end
            end
            S_EX: begin
                if (cls.branch) begin
                    PC_WE     = 1'b1;
                    PCSrc     = PCSRC_BR;
                    OPSrc     = OPSRC_BR;
                    INST_DONE = 1'b1;
                end
            end
            S_MEM: begin
                D_MEM_REQ = 1'b1;
                D_MEM_WE  = cls.store;
                if (D_MEM_RDY && cls.store) begin
                    PC_WE     = 1'b1;
                    OPSrc     = OPSRC_ALU;
                    INST_DONE = 1'b1;
                end
            end
            S_WB: begin
                RF_WE     = 1'b1;
                PC_WE     = 1'b1;
                INST_DONE = 1'b1;
                if (cls.load)                WBSrc = WBSRC_LOAD;
                else if (cls.jal || cls.jalr) WBSrc = WBSRC_PC4;
                if (cls.jal)       PCSrc = PCSRC_JAL;
                else if (cls.jalr) PCSrc = PCSRC_JALR;
            end
            S_HLT: HALT = 1'b1;
            default: ;
        endcase
    end

    // Retire bookkeeping; last_inst feeds the halt-pair detection in ID.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            NUM_INST  <= 32'd0;
            last_inst <= 32'd0;
        end else if (INST_DONE) begin
            NUM_INST  <= NUM_INST + 32'd1;
            last_inst <= IR;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// the FSM cycle by cycle and compares the control outputs every cycle.
module tb_multicycle_ctrl;

    logic        CLK;
    logic        RST;
    logic [31:0] IR;
    logic        I_MEM_RDY;
    logic        D_MEM_RDY;
    logic        Branch_Cond;
    logic        I_MEM_REQ;
    logic        IR_WE;
    logic        PC_WE;
    logic [1:0]  PCSrc;
    logic        RF_WE;
    logic [1:0]  WBSrc;
    logic        D_MEM_REQ;
    logic        D_MEM_WE;
    logic [1:0]  OPSrc;
    logic        INST_DONE;
    logic [31:0] NUM_INST;
    logic        HALT;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .IR          (IR),
        .I_MEM_RDY   (I_MEM_RDY),
        .D_MEM_RDY   (D_MEM_RDY),
        .Branch_Cond (Branch_Cond),
        .I_MEM_REQ   (I_MEM_REQ),
        .IR_WE       (IR_WE),
        .PC_WE       (PC_WE),
        .PCSrc       (PCSrc),
        .RF_WE       (RF_WE),
        .WBSrc       (WBSrc),
        .D_MEM_REQ   (D_MEM_REQ),
        .D_MEM_WE    (D_MEM_WE),
        .OPSrc       (OPSrc),
        .INST_DONE   (INST_DONE),
        .NUM_INST    (NUM_INST),
        .HALT        (HALT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {I_MEM_REQ, IR_WE, PC_WE, PCSrc, RF_WE, WBSrc, D_MEM_REQ, D_MEM_WE, OPSrc, INST_DONE, HALT}
    logic [13:0] ctl;
    assign ctl = {I_MEM_REQ, IR_WE, PC_WE, PCSrc, RF_WE, WBSrc,
                  D_MEM_REQ, D_MEM_WE, OPSrc, INST_DONE, HALT};

    localparam logic [13:0] E_ZERO        = 14'd0;
    localparam logic [13:0] E_IF_WAIT     = {1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [13:0] E_IF_RDY      = {1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [13:0] E_WB_ALU      = {1'b0,1'b0,1'b1,2'b00,1'b1,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [13:0] E_WB_LD       = {1'b0,1'b0,1'b1,2'b00,1'b1,2'b01,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [13:0] E_WB_JAL      = {1'b0,1'b0,1'b1,2'b01,1'b1,2'b10,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [13:0] E_WB_JALR     = {1'b0,1'b0,1'b1,2'b10,1'b1,2'b10,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [13:0] E_BR          = {1'b0,1'b0,1'b1,2'b11,1'b0,2'b00,1'b0,1'b0,2'b10,1'b1,1'b0};
    localparam logic [13:0] E_MEM_LD      = {1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,1'b0,2'b00,1'b0,1'b0};
    localparam logic [13:0] E_MEM_ST_WAIT = {1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,1'b1,2'b00,1'b0,1'b0};
    localparam logic [13:0] E_MEM_ST_RDY  = {1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b1,1'b1,2'b01,1'b1,1'b0};
    localparam logic [13:0] E_NOP         = {1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [13:0] E_HLT         = {1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b1};

    localparam logic [31:0] I_ADD  = 32'h002081b3;
    localparam logic [31:0] I_LW   = 32'h0000a283;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_SW   = 32'h0020a223;
    localparam logic [31:0] I_UNK  = 32'h0000007f;
    localparam logic [31:0] I_JAL  = 32'h000000ef;
    localparam logic [31:0] I_JALR = 32'h00010067;
    localparam logic [31:0] I_HP   = 32'h00c00093;
    localparam logic [31:0] I_HC   = 32'h00008067;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, sample 1 time unit later.
    task automatic cyc(input string tag, input logic [31:0] ir, input logic imr,
                       input logic dmr, input logic bc, input logic [13:0] exp);
        @(negedge CLK);
        IR = ir;
        I_MEM_RDY = imr;
        D_MEM_RDY = dmr;
        Branch_Cond = bc;
        #1;
        chk(tag, 32'(ctl), 32'(exp));
    endtask

    task automatic rst_pulse(input string tag);
        #1 RST = 1'b1;
        #1;
        chk({tag, "_rst_ctl"}, 32'(ctl), 32'(E_ZERO));
        chk({tag, "_rst_num"}, NUM_INST, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        I_MEM_RDY = 1'b0;
        D_MEM_RDY = 1'b0;
        #1;
        chk({tag, "_init_ctl"}, 32'(ctl), 32'(E_ZERO));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        IR = 32'd0;
        I_MEM_RDY = 1'b0;
        D_MEM_RDY = 1'b0;
        Branch_Cond = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_ctl", 32'(ctl), 32'(E_ZERO));
        chk("rst_num", NUM_INST, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("init_ctl", 32'(ctl), 32'(E_ZERO));

        cyc("add_if", I_ADD, 1, 0, 0, E_IF_RDY);
        cyc("add_id", I_ADD, 0, 0, 0, E_ZERO);
        cyc("add_ex", I_ADD, 0, 0, 0, E_ZERO);
        cyc("add_wb", I_ADD, 0, 0, 0, E_WB_ALU);

        // D_MEM_RDY held high outside MEM must have no effect
        cyc("lw_if", I_LW, 1, 1, 0, E_IF_RDY);
        chk("add_num", NUM_INST, 32'd1);
        cyc("lw_id",   I_LW, 0, 1, 0, E_ZERO);
        cyc("lw_ex",   I_LW, 0, 1, 0, E_ZERO);
        cyc("lw_mem0", I_LW, 0, 0, 0, E_MEM_LD);
        cyc("lw_mem1", I_LW, 0, 0, 0, E_MEM_LD);
        cyc("lw_mem2", I_LW, 0, 1, 0, E_MEM_LD);
        cyc("lw_wb",   I_LW, 0, 0, 0, E_WB_LD);

        cyc("beq1_ifw", I_BEQ, 0, 0, 0, E_IF_WAIT);
        chk("lw_num", NUM_INST, 32'd2);
        cyc("beq1_if", I_BEQ, 1, 0, 0, E_IF_RDY);
        cyc("beq1_id", I_BEQ, 0, 0, 1, E_ZERO);
        cyc("beq1_ex", I_BEQ, 0, 0, 1, E_BR);
        cyc("beq0_if", I_BEQ, 1, 0, 0, E_IF_RDY);
        chk("beq1_num", NUM_INST, 32'd3);
        cyc("beq0_id", I_BEQ, 0, 0, 0, E_ZERO);
        cyc("beq0_ex", I_BEQ, 0, 0, 0, E_BR);

        cyc("sw_if", I_SW, 1, 0, 0, E_IF_RDY);
        chk("beq0_num", NUM_INST, 32'd4);
        cyc("sw_id",  I_SW, 0, 0, 0, E_ZERO);
        cyc("sw_ex",  I_SW, 0, 0, 0, E_ZERO);
        cyc("sw_mem", I_SW, 0, 1, 0, E_MEM_ST_RDY);
        cyc("sw_next_if", I_UNK, 0, 0, 0, E_IF_WAIT);
        chk("sw_num", NUM_INST, 32'd5);

        cyc("unk_if", I_UNK, 1, 0, 0, E_IF_RDY);
        cyc("unk_id", I_UNK, 0, 0, 0, E_NOP);

        cyc("jal_if", I_JAL, 1, 0, 0, E_IF_RDY);
        chk("unk_num", NUM_INST, 32'd6);
        cyc("jal_id", I_JAL, 0, 0, 0, E_ZERO);
        cyc("jal_ex", I_JAL, 0, 0, 0, E_ZERO);
        cyc("jal_wb", I_JAL, 0, 0, 0, E_WB_JAL);

        cyc("jalr_if", I_JALR, 1, 0, 0, E_IF_RDY);
        chk("jal_num", NUM_INST, 32'd7);
        cyc("jalr_id", I_JALR, 0, 0, 0, E_ZERO);
        cyc("jalr_ex", I_JALR, 0, 0, 0, E_ZERO);
        cyc("jalr_wb", I_JALR, 0, 0, 0, E_WB_JALR);

        cyc("hp_if", I_HP, 1, 0, 0, E_IF_RDY);
        chk("jalr_num", NUM_INST, 32'd8);
        cyc("hp_id", I_HP, 0, 0, 0, E_ZERO);
        cyc("hp_ex", I_HP, 0, 0, 0, E_ZERO);
        cyc("hp_wb", I_HP, 0, 0, 0, E_WB_ALU);

        cyc("hc_if", I_HC, 1, 0, 0, E_IF_RDY);
        chk("hp_num", NUM_INST, 32'd9);
        cyc("hc_id", I_HC, 0, 0, 0, E_ZERO);
        for (int i = 0; i < 3; i++) begin
            cyc("hlt", I_HC, 1, 1, 1, E_HLT);
        end
        chk("hlt_num", NUM_INST, 32'd9);
        rst_pulse("hlt");

        // Last-retired register was cleared, so HALT_CUR alone is a plain JALR
        cyc("rj_if", I_HC, 1, 0, 0, E_IF_RDY);
        cyc("rj_id", I_HC, 0, 0, 0, E_ZERO);
        cyc("rj_ex", I_HC, 0, 0, 0, E_ZERO);
        cyc("rj_wb", I_HC, 0, 0, 0, E_WB_JALR);

        cyc("swr_if", I_SW, 1, 0, 0, E_IF_RDY);
        chk("rj_num", NUM_INST, 32'd1);
        cyc("swr_id",  I_SW, 0, 0, 0, E_ZERO);
        cyc("swr_ex",  I_SW, 0, 0, 0, E_ZERO);
        cyc("swr_mem", I_SW, 0, 0, 0, E_MEM_ST_WAIT);
        rst_pulse("swr");

        cyc("add2_if", I_ADD, 1, 0, 0, E_IF_RDY);
        cyc("add2_id", I_ADD, 0, 0, 0, E_ZERO);
        cyc("add2_ex", I_ADD, 0, 0, 0, E_ZERO);
        cyc("add2_wb", I_ADD, 0, 0, 0, E_WB_ALU);
        cyc("add2_next", I_ADD, 0, 0, 0, E_IF_WAIT);
        chk("add2_num", NUM_INST, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the PC/IR/RF/memory enables and the PC, write-back and output-port select codes consumed by the datapath and the output-port mux. It also counts retired instructions and detects the HALT sequence.

## Interface
Parameters:
- `HALT_PREV`, 32'h00c00093, first word of the halt pair (`addi x1,x0,12`).
- `HALT_CUR`, 32'h00008067, second word of the halt pair (`jalr x0,0(x1)`).

Ports:
- `CLK`  in  1  single clock; all state is updated on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `IR`  in  32  current instruction register contents; valid from ID onward.
- `I_MEM_RDY`  in  1  instruction memory read data valid.
- `D_MEM_RDY`  in  1  data memory access complete.
- `Branch_Cond`  in  1  ALU branch comparison result, valid in EX.
- `I_MEM_REQ`  out  1  instruction fetch request.
- `IR_WE`  out  1  load IR from instruction memory.
- `PC_WE`  out  1  update PC.
- `PCSrc`  out  2  PC source: 00 PC+4, 01 JAL target, 10 JALR target, 11 branch.
- `RF_WE`  out  1  register-file write enable.
- `WBSrc`  out  2  RF write-data source: 00 ALUOUT, 01 load data, 10 PC+4.
- `D_MEM_REQ`  out  1  data memory request.
- `D_MEM_WE`  out  1  data memory write, active-high; qualifies `D_MEM_REQ`.
- `OPSrc`  out  2  output-port select: 00 RF_WD, 01 ALUOUT, 10 branch.
- `INST_DONE`  out  1  one-cycle pulse when an instruction retires.
- `NUM_INST`  out  32  retired-instruction counter.
- `HALT`  out  1  sticky halt flag.

## Operation
- States: INIT, IF, ID, EX, MEM, WB, HLT. The encoding lives in the package.
- INIT → IF unconditionally. In IF, `I_MEM_REQ`=1; the FSM stays in IF until `I_MEM_RDY`. On `I_MEM_RDY`, `IR_WE`=1 and the FSM goes to ID.
- ID: decode `IR[6:0]`.
  - If the previously retired instruction == `HALT_PREV` and `IR` == `HALT_CUR`, go to HLT. The instruction is not retired and the counter is not incremented.
  - Unknown opcode: retire as a NOP (`INST_DONE`=1, `PC_WE`=1, `PCSrc`=00) and go to IF.
  - Otherwise go to EX.
- EX, by instruction class:
  - BRANCH: `PC_WE`=1, `PCSrc`=11 (the datapath picks the target or PC+4 using `Branch_Cond`), `OPSrc`=10, `INST_DONE`=1, then IF.
  - LOAD and STORE: go to MEM.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: go to WB.
- MEM: `D_MEM_REQ`=1, with `D_MEM_WE`=1 for STORE. The FSM waits for `D_MEM_RDY`.
  - STORE: on ready, `PC_WE`=1, `PCSrc`=00, `OPSrc`=01, `INST_DONE`=1, then IF.
  - LOAD: on ready, go to WB.
- WB: `RF_WE`=1, `PC_WE`=1, `OPSrc`=00, `INST_DONE`=1, then IF.
  - `WBSrc` is 01 for LOAD, 10 for JAL/JALR, otherwise 00.
  - `PCSrc` is 01 for JAL, 10 for JALR, otherwise 00.
- HLT: absorbing state; `HALT`=1 and all enables are 0. Only `RST` leaves it.
- `NUM_INST` increments by 1 on every `INST_DONE` cycle and wraps from 32'hFFFFFFFF to 0.
- The last-retired-instruction register (32 bit) captures `IR` on `INST_DONE`.

## Timing
- All outputs are decoded from the registered state plus `IR` and the ready inputs (Mealy only on the ready/halt terms). There are no registered output delays.
- Reset:
  - `RST` high asynchronously forces state to INIT, `NUM_INST`=0, `HALT`=0, and the last-retired register to 0.
  - In INIT every output is 0 and `OPSrc`/`PCSrc`/`WBSrc` are 00.
  - `RST` asserted mid-instruction aborts it, with no retire and no counter update.
- Minimum cycles per instruction with zero-wait memories: BRANCH 3, STORE 4, ALU/jump/LUI/AUIPC 4, LOAD 5. Each memory wait cycle adds 1.
- `INST_DONE` and `PC_WE` always assert in the same cycle, exactly once per retired instruction.
- A ready input asserted outside its wait state is ignored.

## Structure
- Package `multicycle_pkg`:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP);
  - state enum;
  - `PCSrc`, `OPSrc` and `WBSrc` code constants, shared with the datapath and output-port mux.
- Sub-module `inst_class_decode`: combinational decode from `IR[6:0]` to a one-hot class (alu, load, store, branch, jal, jalr, unknown).

## Test plan
- ADD x3,x1,x2 (32'h002081b3) with zero-wait memories → states INIT, IF, ID, EX, WB; `RF_WE`=1, `WBSrc`=00, `INST_DONE` in cycle 4 after INIT; `NUM_INST`=1.
- LW with `D_MEM_RDY` delayed 2 cycles → MEM held for 3 cycles, `D_MEM_WE`=0, WB with `WBSrc`=01; 7 cycles total.
- BEQ with `Branch_Cond`=1, then with 0 → in EX both times: `PCSrc`=11, `OPSrc`=10, `INST_DONE`=1, `RF_WE`=0; `NUM_INST` +2.
- SW → MEM with `D_MEM_REQ`=`D_MEM_WE`=1, `OPSrc`=01, retires without entering WB.
- 32'h00c00093 followed by 32'h00008067 → first instruction retires; the second reaches HLT from ID; `HALT`=1 permanently; `NUM_INST` unchanged by the second; all enables 0.
- `RST` pulsed while in MEM of a SW → state INIT, `NUM_INST`=0, no `INST_DONE`; then a normal fetch restarts.
